// File: rtl/oddr2_tx_serializer.sv
// Parallel-to-DDR gearbox feeding an ODDR2: FIFO-buffered words are emitted two bits per clock.
// Define ODDR2_SER_MSB_FIRST_EN for MSB-first pair order; LSB-first otherwise.
module oddr2_tx_serializer #(
    parameter int          WIDTH     = 8,
    parameter int          DEPTH     = 4,
    parameter logic [1:0]  IDLE_PAIR = 2'b00
) (
    input  logic             C,
    input  logic             R_N,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             D0,
    output logic             D1,
    output logic             BUSY,
    output logic             DONE
);

    localparam int PAIRS = WIDTH / 2;
    localparam int KW    = $clog2(PAIRS);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q, in_ready_d;
    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             d0_q, d0_d;
    logic             d1_q, d1_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] pair_shift;

    assign push = IN_VALID & in_ready_q;

    always_ff @(posedge C) begin
        if (push) begin
            mem_q[wr_ptr_q] <= IN_DATA;
        end
    end

    // Pops only see words already in the FIFO, so a word written this edge waits one cycle.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        word_d  = word_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    word_d  = mem_q[rd_ptr_q];
                    k_d     = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (k_q != KW'(PAIRS - 1)) begin
                    k_d = k_q + KW'(1);
                end else if (count_q != '0) begin
                    pop    = 1'b1;
                    word_d = mem_q[rd_ptr_q];
                    k_d    = '0;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        in_ready_d = (count_d != CW'(DEPTH));
        busy_d     = (state_d == SHIFT) | (count_d != '0);
    end

    // Outputs are computed from the next word/index so the pair is registered in the load cycle.
    always_comb begin
        d0_d = IDLE_PAIR[0];
        d1_d = IDLE_PAIR[1];
`ifdef ODDR2_SER_MSB_FIRST_EN
        pair_shift = word_d << {k_d, 1'b0};
        if (state_d == SHIFT) begin
            d0_d = pair_shift[WIDTH-1];
            d1_d = pair_shift[WIDTH-2];
        end
`else
        pair_shift = word_d >> {k_d, 1'b0};
        if (state_d == SHIFT) begin
            d0_d = pair_shift[0];
            d1_d = pair_shift[1];
        end
`endif
    end

    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= IDLE;
            k_q        <= '0;
            word_q     <= '0;
            d0_q       <= IDLE_PAIR[0];
            d1_q       <= IDLE_PAIR[1];
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            state_q    <= state_d;
            k_q        <= k_d;
            word_q     <= word_d;
            d0_q       <= d0_d;
            d1_q       <= d1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign IN_READY = in_ready_q;
    assign D0       = d0_q;
    assign D1       = d1_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_oddr2_tx_serializer.sv
// Self-checking bench for oddr2_tx_serializer: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_oddr2_tx_serializer;

    localparam int         WIDTH     = 8;
    localparam int         DEPTH     = 4;
    localparam logic [1:0] IDLE_PAIR = 2'b10;
    localparam int         PAIRS     = WIDTH / 2;

    logic             clk;
    logic             r_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             d0;
    logic             d1;
    logic             busy;
    logic             done;

    int n_checks;
    int n_fail;
    int done_seen;

    logic [WIDTH-1:0] m_q [$];
    logic [WIDTH-1:0] tx_q [$];
    bit               m_active;
    int               m_k;
    logic [WIDTH-1:0] m_word;
    bit               exp_ready;
    bit               exp_busy;
    bit               exp_done;
    bit               exp_d0;
    bit               exp_d1;

    oddr2_tx_serializer #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .IDLE_PAIR(IDLE_PAIR)
    ) dut (
        .C       (clk),
        .R_N     (r_n),
        .IN_DATA (in_data),
        .IN_VALID(in_valid),
        .IN_READY(in_ready),
        .D0      (d0),
        .D1      (d1),
        .BUSY    (busy),
        .DONE    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active  = 1'b0;
        m_k       = 0;
        m_word    = '0;
        exp_ready = 1'b0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_d0    = IDLE_PAIR[0];
        exp_d1    = IDLE_PAIR[1];
    endtask

    // One clock edge of the reference: word queue plus "current word, pair number".
    task automatic model_step(input bit push, input logic [WIDTH-1:0] data);
        bit pop;
        pop = (!m_active || m_k == PAIRS - 1) && (m_q.size() > 0);
        exp_done = 1'b0;
        if (pop) begin
            m_word   = m_q.pop_front();
            m_k      = 0;
            m_active = 1'b1;
        end else if (m_active && m_k < PAIRS - 1) begin
            m_k++;
        end else if (m_active) begin
            m_active = 1'b0;
            exp_done = 1'b1;
        end
        if (push) m_q.push_back(data);
        exp_ready = (m_q.size() != DEPTH);
        exp_busy  = m_active || (m_q.size() != 0);
        if (m_active) begin
`ifdef ODDR2_SER_MSB_FIRST_EN
            exp_d0 = ((m_word >> (WIDTH - 1 - 2 * m_k)) & 1) != 0;
            exp_d1 = ((m_word >> (WIDTH - 2 - 2 * m_k)) & 1) != 0;
`else
            exp_d0 = ((m_word >> (2 * m_k)) & 1) != 0;
            exp_d1 = ((m_word >> (2 * m_k + 1)) & 1) != 0;
`endif
        end else begin
            exp_d0 = IDLE_PAIR[0];
            exp_d1 = IDLE_PAIR[1];
        end
    endtask

    task automatic compare_all(input string where);
        checkOutput({where, ".D0"}, d0, exp_d0);
        checkOutput({where, ".D1"}, d1, exp_d1);
        checkOutput({where, ".IN_READY"}, in_ready, exp_ready);
        checkOutput({where, ".BUSY"}, busy, exp_busy);
        checkOutput({where, ".DONE"}, done, exp_done);
    endtask

    task automatic applyStimulus(input bit valid, input logic [WIDTH-1:0] data, input string where);
        bit push;
        @(negedge clk);
        in_valid = valid;
        in_data  = data;
        push     = valid && exp_ready;
        @(posedge clk);
        model_step(push, data);
        #1;
        compare_all(where);
        if (done) done_seen++;
    endtask

    // Offers tx_q words in order, holding each until accepted, then waits for the stream to drain.
    task automatic run_feed(input int max_cycles, input string where);
        int  cycles;
        bit  have;
        logic [WIDTH-1:0] w;
        cycles = 0;
        while ((tx_q.size() > 0 || m_active || m_q.size() > 0 || exp_done) && cycles < max_cycles) begin
            have = (tx_q.size() > 0);
            w    = have ? tx_q[0] : '0;
            if (have && exp_ready) void'(tx_q.pop_front());
            applyStimulus(have, w, where);
            cycles++;
        end
        checkOutput({where, ".drain_timeout"}, (cycles >= max_cycles), 0);
    endtask

    task automatic do_reset(input string where);
        @(negedge clk);
        in_valid = 1'b0;
        #2 r_n = 1'b0;
        #1;
        model_reset();
        checkOutput({where, ".rst_D0"}, d0, IDLE_PAIR[0]);
        checkOutput({where, ".rst_D1"}, d1, IDLE_PAIR[1]);
        checkOutput({where, ".rst_IN_READY"}, in_ready, 0);
        checkOutput({where, ".rst_BUSY"}, busy, 0);
        checkOutput({where, ".rst_DONE"}, done, 0);
        repeat (2) @(negedge clk);
        r_n = 1'b1;
        applyStimulus(1'b0, '0, {where, ".release"});
        checkOutput({where, ".ready_after_release"}, in_ready, 1);
    endtask

    initial begin
        int cycles;
        n_checks  = 0;
        n_fail    = 0;
        done_seen = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        r_n       = 1'b1;
        model_reset();

        #2 r_n = 1'b0;
        #1;
        checkOutput("init_rst_D0", d0, IDLE_PAIR[0]);
        checkOutput("init_rst_D1", d1, IDLE_PAIR[1]);
        checkOutput("init_rst_IN_READY", in_ready, 0);
        checkOutput("init_rst_BUSY", busy, 0);
        repeat (2) @(negedge clk);
        r_n = 1'b1;
        applyStimulus(1'b0, '0, "release");
        checkOutput("init_ready_after_release", in_ready, 1);

        tx_q.push_back(8'hB4);
        run_feed(40, "single_b4");

        done_seen = 0;
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h00);
        run_feed(40, "b2b");
        checkOutput("b2b_done_count", done_seen, 1);

        for (int i = 0; i < 5; i++) tx_q.push_back(8'h11 * (i + 1));
        run_feed(60, "full_fifo");

        for (int i = 0; i < 4; i++) tx_q.push_back(WIDTH'($urandom));
        cycles = 0;
        while (!(m_active && m_k == 2 && m_q.size() == 3) && cycles < 20) begin
            logic [WIDTH-1:0] w;
            bit have;
            have = (tx_q.size() > 0);
            w    = have ? tx_q[0] : '0;
            if (have && exp_ready) void'(tx_q.pop_front());
            applyStimulus(have, w, "pre_reset");
            cycles++;
        end
        checkOutput("midword_setup_timeout", (cycles >= 20), 0);
        tx_q.delete();
        do_reset("midword");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, "post_reset_idle");

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, WIDTH'($urandom), "random");
        end
        run_feed(60, "random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oddr2_tx_serializer.md
# oddr2_tx_serializer

Output gearbox that sits directly upstream of the ODDR2 output DDR register. It accepts parallel words over a ready/valid handshake and buffers them in a small FIFO. It drives the register's D0/D1 pair each clock with two bits of the current word. When no data is queued it drives a fixed idle pattern, so the pin toggles two bits per clock with no gaps inside a burst.

## Interface
Parameters:
- WIDTH, 8, word width in bits; even, >= 4
- DEPTH, 4, FIFO depth in words; power of 2, >= 2
- IDLE_PAIR, 2'b00, {D1,D0} value driven when idle and in reset

Ports:
- C  input  1  clock; also drives the ODDR2 C0 domain
- R_N  input  1  reset, asynchronous, active-low
- IN_DATA  input  WIDTH  parallel word
- IN_VALID  input  1  IN_DATA valid
- IN_READY  output  1  FIFO can accept a word
- D0  output  1  to ODDR2 D0 (first half-cycle bit)
- D1  output  1  to ODDR2 D1 (second half-cycle bit)
- BUSY  output  1  shifter holds a word, or FIFO non-empty
- DONE  output  1  one-cycle pulse when a burst ends

## Operation
- Reset (R_N=0, asynchronous):
  - FIFO is emptied and the state goes to IDLE.
  - {D1,D0} = IDLE_PAIR; IN_READY=0, BUSY=0, DONE=0.
- Word transfer occurs on a rising edge with IN_VALID & IN_READY; the word is written to the FIFO.
- The FIFO has no fall-through. A word written at edge N is readable from edge N+1.
- IN_READY is a register with next value !(count_next==DEPTH).
  - It rises at the first edge after reset release.
  - When full, a push is impossible, so a simultaneous push and pop cannot overflow.
  - When not full, a simultaneous push and pop leaves the count unchanged.
- State machine, IDLE / SHIFT, with pair index k in 0..WIDTH/2-1:
  - IDLE: if the FIFO is non-empty, pop, load the shifter, k=0, go to SHIFT. Otherwise drive IDLE_PAIR.
  - SHIFT, k < WIDTH/2-1: k++.
  - SHIFT, k = WIDTH/2-1 with FIFO non-empty: pop, load, k=0, stay in SHIFT (no gap).
  - SHIFT, k = WIDTH/2-1 with FIFO empty: go to IDLE and pulse DONE for one cycle.
- Bit order, default LSB-first: pair k gives D0=word[2k], D1=word[2k+1].
- D0/D1 are registered outputs; there is no combinational path from IN_* to D*.
- BUSY is registered: (state==SHIFT) | (count!=0).
- Reset mid-word: the word in flight and all queued words are discarded; the outputs go to IDLE_PAIR immediately.

## Timing
- A word accepted at edge N, with the FIFO empty and state IDLE:
  - loads at edge N+1;
  - pair k is visible from edge N+1+k to N+2+k;
  - the last pair is visible from edge N+WIDTH/2.
- Back-to-back words produce a continuous stream of WIDTH/2 pairs per word.
- Sustained throughput is one word per WIDTH/2 cycles.
- DONE is high for the single cycle after the last pair, in which D = IDLE_PAIR.
- IN_READY deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after a pop from full.

## Configuration
- ODDR2_SER_MSB_FIRST_EN
  - Defined: MSB-first order, pair k gives D0=word[WIDTH-1-2k], D1=word[WIDTH-2-2k].
  - Undefined: LSB-first order as in Operation.
  - Timing, handshake and FIFO behaviour are identical either way.

## Test plan
- Reset and idle (IDLE_PAIR=2'b10):
  - assert R_N=0 mid-stream → D1=1, D0=0, IN_READY=0, BUSY=0 immediately;
  - release → IN_READY=1 one edge later.
- Single word 0xB4, WIDTH=8, LSB-first:
  - accept at edge N → (D0,D1) = (0,0),(1,0),(1,1),(0,1) over edges N+1..N+4;
  - DONE=1 in cycle N+5 with IDLE pair.
- Same 0xB4 with ODDR2_SER_MSB_FIRST_EN → (D0,D1) = (1,0),(1,1),(0,1),(0,0).
- Back-to-back 0xFF then 0x00 with IN_VALID held high → D0=D1=1 for 4 cycles, then 0 for 4 cycles, no idle gap, a single DONE after the 8th pair.
- Full FIFO, DEPTH=4, with the output paused on a word:
  - push 5 words → IN_READY=0 after the 4th push into the empty FIFO;
  - the 5th word stalls and is accepted the edge after the next pop;
  - all 5 words are emitted in order, none lost.
- Reset asserted at k=2 of a word with 3 words queued → outputs IDLE_PAIR at once; after release, no stale pairs emitted and BUSY stays 0.
